// File: rtl/pld_wr_arbiter.sv
// Round-robin arbiter sharing the payload-FIFO write port between producers, one whole measurement per grant.
// Optional: define PLD_ARB_SRC_TAG_EN to stamp the source index into the top bits of each burst's first word.

module pld_wr_arbiter_chk #(
    parameter int NUM_SRC  = 4,
    parameter int SRC_BITS = 2
) (
    input logic                clk,
    input logic                reset,
    input logic                busy,
    input logic [SRC_BITS-1:0] grant_idx,
    input logic [NUM_SRC-1:0]  src_req
);

    logic [NUM_SRC-1:0] req_at_grant_s;

    assign req_at_grant_s = src_req >> grant_idx;

    // A producer must keep its request up until its measurement has been fully drained.
    a_req_held_in_burst: assert property (@(posedge clk) disable iff (!reset)
        busy |-> req_at_grant_s[0])
        else $error("pld_wr_arbiter: src_req dropped by source %0d mid-burst", grant_idx);

endmodule

module pld_wr_arbiter #(
    parameter int NUM_SRC        = 4,
    parameter int SRC_BITS       = 2,
    parameter int WORD_WIDTH     = 64,
    parameter int WORDS_PER_MEAS = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            src_req,
    input  logic [NUM_SRC*WORD_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]            src_ack,
    output logic [WORD_WIDTH-1:0]         pld_fifo_din,
    output logic                          pld_fifo_wr,
    input  logic                          pld_fifo_full,
    output logic [SRC_BITS-1:0]           grant_idx,
    output logic                          busy
);

    localparam int                     CNT_W    = $clog2(WORDS_PER_MEAS) + 1;
    localparam logic [CNT_W-1:0]       LAST_CNT = CNT_W'(WORDS_PER_MEAS - 1);
    localparam logic [SRC_BITS-1:0]    LAST_SRC = SRC_BITS'(NUM_SRC - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                  state_r, state_s;
    logic [SRC_BITS-1:0]     rr_ptr_r, rr_ptr_s;
    logic [SRC_BITS-1:0]     grant_r, grant_s;
    logic [CNT_W-1:0]        word_cnt_r, word_cnt_s;

    logic [2*NUM_SRC-1:0]    req_rot_s;
    logic                    win_hit_s;
    logic [SRC_BITS-1:0]     win_idx_s;
    int                      cand_s;
    logic                    wr_s;
    logic [WORD_WIDTH-1:0]   grant_data_s;
    logic [WORD_WIDTH-1:0]   din_s;
    logic [NUM_SRC-1:0]      ack_s;

    // Rotating-priority search: bit i of req_rot_s is the request of source (rr_ptr + i) mod NUM_SRC.
    always_comb begin
        req_rot_s = {src_req, src_req} >> rr_ptr_r;
        win_hit_s = 1'b0;
        win_idx_s = {SRC_BITS{1'b0}};
        cand_s    = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!win_hit_s && req_rot_s[i]) begin
                cand_s = int'(rr_ptr_r) + i;
                if (cand_s >= NUM_SRC) begin
                    cand_s = cand_s - NUM_SRC;
                end else begin
                    cand_s = cand_s;
                end
                win_hit_s = 1'b1;
                win_idx_s = SRC_BITS'(cand_s);
            end else begin
                win_hit_s = win_hit_s;
            end
        end
    end

    // Payload path: select the granted head word and the matching pop strobe.
    always_comb begin
        wr_s         = (state_r == BURST) && !pld_fifo_full;
        grant_data_s = {WORD_WIDTH{1'b0}};
        ack_s        = {NUM_SRC{1'b0}};
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_r == SRC_BITS'(i)) begin
                grant_data_s = src_data[i*WORD_WIDTH +: WORD_WIDTH];
                ack_s[i]     = wr_s;
            end else begin
                ack_s[i]     = 1'b0;
            end
        end
        if (state_r == BURST) begin
            din_s = grant_data_s;
`ifdef PLD_ARB_SRC_TAG_EN
            if (word_cnt_r == {CNT_W{1'b0}}) begin
                din_s[WORD_WIDTH-1 -: SRC_BITS] = grant_r;
            end else begin
                din_s = din_s;
            end
`endif
        end else begin
            // Held at zero outside a burst so every output reads 0 while idle or in reset.
            din_s = {WORD_WIDTH{1'b0}};
        end
    end

    // Next-state logic: arbitrate in IDLE, drain exactly WORDS_PER_MEAS words in BURST.
    always_comb begin
        state_s    = state_r;
        rr_ptr_s   = rr_ptr_r;
        grant_s    = grant_r;
        word_cnt_s = word_cnt_r;
        case (state_r)
            IDLE: begin
                if (win_hit_s) begin
                    grant_s    = win_idx_s;
                    word_cnt_s = {CNT_W{1'b0}};
                    state_s    = BURST;
                end else begin
                    grant_s    = {SRC_BITS{1'b0}};
                end
            end
            BURST: begin
                if (wr_s) begin
                    if (word_cnt_r == LAST_CNT) begin
                        state_s    = IDLE;
                        word_cnt_s = {CNT_W{1'b0}};
                        grant_s    = {SRC_BITS{1'b0}};
                        if (grant_r == LAST_SRC) begin
                            rr_ptr_s = {SRC_BITS{1'b0}};
                        end else begin
                            rr_ptr_s = grant_r + SRC_BITS'(1'b1);
                        end
                    end else begin
                        word_cnt_s = word_cnt_r + CNT_W'(1'b1);
                    end
                end else begin
                    word_cnt_s = word_cnt_r;
                end
            end
            default: begin
                state_s    = IDLE;
                grant_s    = {SRC_BITS{1'b0}};
                word_cnt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            rr_ptr_r   <= {SRC_BITS{1'b0}};
            grant_r    <= {SRC_BITS{1'b0}};
            word_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= state_s;
            rr_ptr_r   <= rr_ptr_s;
            grant_r    <= grant_s;
            word_cnt_r <= word_cnt_s;
        end
    end

    assign src_ack      = ack_s;
    assign pld_fifo_wr  = wr_s;
    assign pld_fifo_din = din_s;
    assign grant_idx    = grant_r;
    assign busy         = (state_r == BURST);

    pld_wr_arbiter_chk #(
        .NUM_SRC  (NUM_SRC),
        .SRC_BITS (SRC_BITS)
    ) u_chk (
        .clk       (clk),
        .reset     (reset),
        .busy      (busy),
        .grant_idx (grant_idx),
        .src_req   (src_req)
    );

endmodule

// File: tb/tb_pld_wr_arbiter.sv
// Directed bench for pld_wr_arbiter: a 4-source instance with a fallthrough-FIFO producer model
// and a 3-source instance for index wrap-around.

module tb_pld_wr_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   src_req;
    logic [255:0] src_data;
    logic [3:0]   src_ack;
    logic [63:0]  pld_fifo_din;
    logic         pld_fifo_wr;
    logic         pld_fifo_full;
    logic [1:0]   grant_idx;
    logic         busy;

    logic [2:0]   req3;
    logic [191:0] data3;
    logic [2:0]   ack3;
    logic [63:0]  din3;
    logic         wr3;
    logic [1:0]   grant3;
    logic         busy3;

    int vectors     = 0;
    int miscompares = 0;
    int pop_cnt [4] = '{default: 0};
    int exp_cnt [4] = '{default: 0};
    int wr_count    = 0;
    int c0;

    always #5 clk = ~clk;

    pld_wr_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .src_req       (src_req),
        .src_data      (src_data),
        .src_ack       (src_ack),
        .pld_fifo_din  (pld_fifo_din),
        .pld_fifo_wr   (pld_fifo_wr),
        .pld_fifo_full (pld_fifo_full),
        .grant_idx     (grant_idx),
        .busy          (busy)
    );

    pld_wr_arbiter #(.NUM_SRC(3), .SRC_BITS(2), .WORD_WIDTH(64), .WORDS_PER_MEAS(2)) dut3 (
        .clk           (clk),
        .reset         (reset),
        .src_req       (req3),
        .src_data      (data3),
        .src_ack       (ack3),
        .pld_fifo_din  (din3),
        .pld_fifo_wr   (wr3),
        .pld_fifo_full (1'b0),
        .grant_idx     (grant3),
        .busy          (busy3)
    );

    function automatic logic [63:0] src_word(input int s, input int k);
        return 64'hC0DE_0000_0000_0000 | (64'(s) << 16) | 64'(k);
    endfunction

    function automatic logic [63:0] exp_din(input int g, input int k, input bit first);
        logic [63:0] w;
        w = src_word(g, k);
`ifdef PLD_ARB_SRC_TAG_EN
        if (first) w[63:62] = 2'(g);
`endif
        return w;
    endfunction

    // Fallthrough producer FIFOs: head word index advances on each acknowledged pop.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (src_ack[i]) pop_cnt[i] <= pop_cnt[i] + 1;
        end
        if (pld_fifo_wr) wr_count <= wr_count + 1;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) src_data[i*64 +: 64] = src_word(i, pop_cnt[i]);
    end

    assign data3 = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr_word(input int g, input bit first);
        #1;
        check_val("burst_busy", 64'(busy), 64'd1);
        check_val("burst_grant", 64'(grant_idx), 64'(g));
        check_val("burst_wr", 64'(pld_fifo_wr), 64'd1);
        check_val("burst_ack", 64'(src_ack), 64'(4'b0001 << g));
        check_val("burst_din", pld_fifo_din, exp_din(g, exp_cnt[g], first));
        exp_cnt[g]++;
    endtask

    task automatic chk_idle(input string tag);
        #1;
        check_val(tag, {busy, pld_fifo_wr, src_ack, grant_idx}, 64'd0);
    endtask

    initial begin
        reset = 1'b0; src_req = 4'b0000; pld_fifo_full = 1'b0; req3 = 3'b000;
        repeat (2) tick();
        #1;
        check_val("rst_ctrl", {busy, pld_fifo_wr, src_ack, grant_idx}, 64'd0);
        check_val("rst_din", pld_fifo_din, 64'd0);
        tick();
        reset = 1'b1;

        // Single source: one arbitration cycle then two back-to-back writes.
        src_req = 4'b0100;
        chk_idle("single_arb_idle");
        tick(); wr_word(2, 1'b1);
        tick(); wr_word(2, 1'b0);
        tick(); src_req = 4'b0000;
        chk_idle("single_done_idle");

        // All request: rr_ptr is 3 after serving source 2, so the order starts at 3.
        src_req = 4'b1111;
        c0 = wr_count;
        for (int m = 0; m < 8; m++) begin
            chk_idle("rr_arb_idle");
            tick(); wr_word((3 + m) % 4, 1'b1);
            tick(); wr_word((3 + m) % 4, 1'b0);
            tick();
        end
        check_val("rr_writes_24cyc", 64'(wr_count - c0), 64'd16);
        src_req = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("no_req_idle");
        end

        // Backpressure on the last word of a source-1 burst while others request.
        src_req = 4'b0010;
        tick(); wr_word(1, 1'b1);
        src_req = 4'b1011;
        tick();
        for (int s = 0; s < 5; s++) begin
            pld_fifo_full = 1'b1;
            #1;
            check_val("stall_wr", 64'(pld_fifo_wr), 64'd0);
            check_val("stall_ack", 64'(src_ack), 64'd0);
            check_val("stall_grant", {63'd0, busy} | (64'(grant_idx) << 1), 64'd3);
            tick();
        end
        pld_fifo_full = 1'b0;
        wr_word(1, 1'b0);
        tick();
        chk_idle("post_stall_idle");

        // rr_ptr is 2, requests 1011 -> source 3; reset lands after its first word.
        tick(); wr_word(3, 1'b1);
        tick();
        reset = 1'b0;
        src_req = 4'b0000;
        #1;
        check_val("midrst_ctrl", {busy, pld_fifo_wr, src_ack, grant_idx}, 64'd0);
        check_val("midrst_din", pld_fifo_din, 64'd0);
        tick();
        reset = 1'b1;
        src_req = 4'b1000;
        chk_idle("after_rst_idle");
        tick(); wr_word(3, 1'b1);
        tick(); wr_word(3, 1'b0);
        tick();
        src_req = 4'b0000;
        chk_idle("after_rst_done");

        // Three sources: 101 -> grants 0, 2, then wrap back to 0.
        req3 = 3'b101;
        for (int m = 0; m < 3; m++) begin
            #1;
            check_val("wrap_idle_busy", 64'(busy3), 64'd0);
            tick();
            #1;
            check_val("wrap_grant_w0", 64'(grant3), (m == 1) ? 64'd2 : 64'd0);
            check_val("wrap_wr", 64'(wr3), 64'd1);
            tick();
            #1;
            check_val("wrap_grant_w1", 64'(grant3), (m == 1) ? 64'd2 : 64'd0);
            check_val("wrap_din_w1", din3, (m == 1) ? 64'h3333_3333_3333_3333 : 64'h1111_1111_1111_1111);
            tick();
        end
        req3 = 3'b000;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
